// File: rtl/requantize_16_top.sv
// rtl/requantize_16_top.sv - per-channel int32->int8 requantizer, LANES lanes, M/E parameter RAMs

module requantize_16_dfram #(
  parameter int W     = 32,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);
  logic [W-1:0] mem [DEPTH];

  // sync write, sync read; read returns old contents on same-address collision
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

module requantize_16_top #(
  parameter int LANES = 16,
  parameter int DEPTH = 1 << 20,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 m_wr_en,
  input  logic [AW-1:0]        m_wr_addr,
  input  logic [LANES*32-1:0]  m_wr_data,
  input  logic                 e_wr_en,
  input  logic [AW-1:0]        e_wr_addr,
  input  logic [LANES*8-1:0]   e_wr_data,
  input  logic                 start,
  input  logic [AW-1:0]        addr,
  input  logic [LANES*32-1:0]  acc_vec,
  input  logic [7:0]           out_zp,
  output logic                 ready,
  output logic                 done,
  output logic [LANES*8-1:0]   ofm_vec
);
  typedef enum logic [2:0] {IDLE, RD, MUL, SHF, OUT} state_t;

  state_t state, state_nxt;
  logic                 rd_en;
  logic [LANES*32-1:0]  m_rd;
  logic [LANES*8-1:0]   e_rd;
  logic [LANES*32-1:0]  acc_q;
  logic signed [7:0]    zp_q;

  logic signed [7:0]  e_raw [LANES];
  logic signed [7:0]  e_cl  [LANES];
  logic [4:0]         l_sh  [LANES];
  logic [4:0]         r_sh  [LANES];
  logic [31:0]        x_d   [LANES];
  logic [31:0]        m_k   [LANES];
  logic signed [63:0] p_d   [LANES];
  logic signed [63:0] sum_d [LANES];
  logic signed [31:0] h_d   [LANES];
  logic signed [31:0] h_q   [LANES];
  logic [31:0]        mask  [LANES];
  logic [31:0]        rem   [LANES];
  logic [31:0]        thr   [LANES];
  logic signed [31:0] y_d   [LANES];
  logic signed [31:0] y_q   [LANES];
  logic signed [32:0] z_d   [LANES];
  logic [7:0]         o_d   [LANES];

  assign ready = (state == IDLE);
  assign rd_en = (state == IDLE) && start;

  requantize_16_dfram #(.W(LANES*32), .DEPTH(DEPTH), .AW(AW)) u_dfram_M (
    .clk(clk), .wr_en(m_wr_en), .wr_addr(m_wr_addr), .wr_data(m_wr_data),
    .rd_en(rd_en), .rd_addr(addr), .rd_data(m_rd)
  );

  requantize_16_dfram #(.W(LANES*8), .DEPTH(DEPTH), .AW(AW)) u_dfram_E (
    .clk(clk), .wr_en(e_wr_en), .wr_addr(e_wr_addr), .wr_data(e_wr_data),
    .rd_en(rd_en), .rd_addr(addr), .rd_data(e_rd)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // linear sequence; start is only honoured in IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RD;
      RD:      state_nxt = MUL;
      MUL:     state_nxt = SHF;
      SHF:     state_nxt = OUT;
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // shift decode: clamp E to +-31 and split into left/right amounts
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      e_raw[k] = e_rd[k*8 +: 8];
      if (e_raw[k] > 8'sd31)       e_cl[k] = 8'sd31;
      else if (e_raw[k] < -8'sd31) e_cl[k] = -8'sd31;
      else                         e_cl[k] = e_raw[k];
      l_sh[k] = e_cl[k][7] ? 5'd0 : e_cl[k][4:0];
      r_sh[k] = e_cl[k][7] ? 5'(-e_cl[k]) : 5'd0;
    end
  end

  // saturating rounding doubling high multiply; divide by 2^31 truncates toward zero
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      x_d[k]   = acc_q[k*32 +: 32] << l_sh[k];
      m_k[k]   = m_rd[k*32 +: 32];
      p_d[k]   = 64'($signed(x_d[k])) * 64'($signed(m_k[k]));
      sum_d[k] = p_d[k] + (p_d[k][63] ? -64'sd1073741823 : 64'sd1073741824);
      h_d[k]   = sum_d[k][62:31] + {31'd0, (sum_d[k][63] && (|sum_d[k][30:0]))};
      if (x_d[k] == 32'h8000_0000 && m_k[k] == 32'h8000_0000) h_d[k] = 32'sh7FFF_FFFF;
    end
  end

  // rounding divide by power of two, ties away from zero
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      mask[k] = (32'd1 << r_sh[k]) - 32'd1;
      rem[k]  = h_q[k] & mask[k];
      thr[k]  = (mask[k] >> 1) + {31'd0, h_q[k][31]};
      y_d[k]  = (h_q[k] >>> r_sh[k]) + ((rem[k] > thr[k]) ? 32'sd1 : 32'sd0);
    end
  end

  // zero-point add and int8 saturation
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      z_d[k] = 33'(y_q[k]) + 33'(zp_q);
      if (z_d[k] > 33'sd127)       o_d[k] = 8'h7F;
      else if (z_d[k] < -33'sd128) o_d[k] = 8'h80;
      else                         o_d[k] = z_d[k][7:0];
    end
  end

  // request capture, pipeline stage registers and output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      zp_q    <= '0;
      done    <= 1'b0;
      ofm_vec <= '0;
      for (int k = 0; k < LANES; k++) begin
        h_q[k] <= '0;
        y_q[k] <= '0;
      end
    end else begin
      done <= (state == OUT);
      if (rd_en) begin
        acc_q <= acc_vec;
        zp_q  <= out_zp;
      end
      for (int k = 0; k < LANES; k++) begin
        if (state == MUL) h_q[k] <= h_d[k];
        if (state == SHF) y_q[k] <= y_d[k];
        if (state == OUT) ofm_vec[k*8 +: 8] <= o_d[k];
      end
    end
  end
endmodule

// File: tb/tb_requantize_16_top.sv
// tb/tb_requantize_16_top.sv - directed self-checking bench for requantize_16_top

module tb_requantize_16_top;
  localparam int LANES = 16;
  localparam int AW    = 20;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                m_wr_en, e_wr_en, start;
  logic [AW-1:0]       m_wr_addr, e_wr_addr, addr;
  logic [LANES*32-1:0] m_wr_data, acc_vec;
  logic [LANES*8-1:0]  e_wr_data;
  logic [7:0]          out_zp;
  logic                ready, done;
  logic [LANES*8-1:0]  ofm_vec;

  int nvec = 0;
  int nerr = 0;

  logic [LANES*32-1:0] m_tab [16];
  logic [LANES*8-1:0]  e_tab [16];

  requantize_16_top dut (
    .clk(clk), .rst_n(rst_n),
    .m_wr_en(m_wr_en), .m_wr_addr(m_wr_addr), .m_wr_data(m_wr_data),
    .e_wr_en(e_wr_en), .e_wr_addr(e_wr_addr), .e_wr_data(e_wr_data),
    .start(start), .addr(addr), .acc_vec(acc_vec), .out_zp(out_zp),
    .ready(ready), .done(done), .ofm_vec(ofm_vec)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rep8(input logic [7:0] v);
    return {LANES{v}};
  endfunction

  function automatic logic [511:0] rep32(input logic [31:0] v);
    return {LANES{v}};
  endfunction

  function automatic logic [7:0] ref_lane(input logic [31:0] a, input logic [31:0] m,
                                          input logic [7:0] e, input logic [7:0] zp);
    int s, lsh, rsh, x, h, y;
    longint p, nudge, mask, rem, thr, z, hl;
    s = int'($signed(e));
    if (s > 31) s = 31;
    if (s < -31) s = -31;
    lsh = (s > 0) ? s : 0;
    rsh = (s < 0) ? -s : 0;
    x = int'(a) << lsh;
    if (x == int'(32'h8000_0000) && int'(m) == int'(32'h8000_0000)) begin
      h = 32'sh7FFF_FFFF;
    end else begin
      p = longint'(x) * longint'(int'(m));
      nudge = (p >= 0) ? 64'sd1073741824 : -64'sd1073741823;
      h = int'((p + nudge) / 64'sd2147483648);
    end
    hl = h;
    mask = (64'sd1 << rsh) - 1;
    rem = hl & mask;
    thr = (mask >> 1) + ((h < 0) ? 1 : 0);
    y = (h >>> rsh) + ((rem > thr) ? 1 : 0);
    z = longint'(y) + longint'($signed(zp));
    if (z > 127) z = 127;
    if (z < -128) z = -128;
    return z[7:0];
  endfunction

  task automatic wr_entry(input logic [AW-1:0] a, input logic [511:0] mv, input logic [127:0] ev);
    @(negedge clk);
    m_wr_en = 1'b1; m_wr_addr = a; m_wr_data = mv;
    e_wr_en = 1'b1; e_wr_addr = a; e_wr_data = ev;
    @(negedge clk);
    m_wr_en = 1'b0; e_wr_en = 1'b0;
  endtask

  task automatic run_req(input logic [AW-1:0] a, input logic [511:0] acc, input logic [7:0] zp,
                         input bit poke, output logic [127:0] res, output int lat,
                         output logic busy_rdy);
    @(negedge clk);
    addr = a; acc_vec = acc; out_zp = zp; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    busy_rdy = ready;
    if (poke) begin
      addr = a + 1; acc_vec = ~acc; out_zp = ~zp; start = 1'b1;
    end
    while (!done && lat < 12) begin
      @(negedge clk);
      start = 1'b0;
      lat++;
    end
    res = ofm_vec;
  endtask

  initial begin
    logic [127:0] res, exp;
    logic [511:0] mv, av;
    logic [127:0] ev;
    logic [7:0]   zp;
    logic         brdy;
    int           lat, seen;

    rst_n = 1'b0; start = 1'b0; m_wr_en = 1'b0; e_wr_en = 1'b0;
    m_wr_addr = '0; e_wr_addr = '0; m_wr_data = '0; e_wr_data = '0;
    addr = '0; acc_vec = '0; out_zp = '0;
    repeat (3) @(negedge clk);
    chk("reset_ready", 128'(ready), 128'(1));
    chk("reset_done", 128'(done), 128'(0));
    chk("reset_ofm", ofm_vec, 128'(0));
    rst_n = 1'b1;

    wr_entry(0, rep32(32'h4000_0000), rep8(8'h00));
    wr_entry(1, rep32(32'h4000_0000), rep8(8'hFD));
    wr_entry(2, rep32(32'h4000_0000), rep8(8'h02));
    wr_entry(3, rep32(32'h8000_0000), rep8(8'h00));

    run_req(0, rep32(32'd100), 8'd37, 1'b0, res, lat, brdy);
    chk("basic_latency", 128'(lat), 128'(4));
    chk("basic_busy_ready", 128'(brdy), 128'(0));
    chk("basic_ofm", res, rep8(8'd87));
    @(negedge clk);
    chk("done_single_cycle", 128'(done), 128'(0));
    chk("ofm_held", ofm_vec, rep8(8'd87));

    run_req(1, rep32(-32'sd1000), 8'd37, 1'b0, res, lat, brdy);
    chk("neg_round", res, rep8(8'hE6));
    run_req(2, rep32(32'd10), 8'd37, 1'b0, res, lat, brdy);
    chk("left_shift", res, rep8(8'd57));
    run_req(0, rep32(32'd1000000), 8'd37, 1'b0, res, lat, brdy);
    chk("sat_pos", res, rep8(8'h7F));
    run_req(3, rep32(32'h8000_0000), 8'd37, 1'b0, res, lat, brdy);
    chk("sat_min_min", res, rep8(8'h7F));
    run_req(0, rep32(-32'sd1000000), 8'd37, 1'b0, res, lat, brdy);
    chk("sat_neg", res, rep8(8'h80));

    for (int ent = 4; ent < 12; ent++) begin
      for (int k = 0; k < LANES; k++) begin
        mv[k*32 +: 32] = $urandom;
        ev[k*8 +: 8]   = 8'($urandom_range(0, 20)) - 8'd14;
      end
      mv[0 +: 32]  = 32'h8000_0000;
      mv[32 +: 32] = 32'h4000_0000;
      ev[16 +: 8]  = 8'd40;
      ev[24 +: 8]  = 8'hD8;
      m_tab[ent] = mv;
      e_tab[ent] = ev;
      if (ent < 8) wr_entry(AW'(ent), mv, ev);
      else begin
        dut.u_dfram_M.mem[ent] = mv;
        dut.u_dfram_E.mem[ent] = ev;
      end
    end

    for (int ent = 4; ent < 12; ent++) begin
      for (int k = 0; k < LANES; k++)
        av[k*32 +: 32] = 32'($urandom_range(0, 200000)) - 32'd100000;
      av[0 +: 32] = 32'h8000_0000;
      zp = 8'($urandom);
      for (int k = 0; k < LANES; k++)
        exp[k*8 +: 8] = ref_lane(av[k*32 +: 32], m_tab[ent][k*32 +: 32], e_tab[ent][k*8 +: 8], zp);
      run_req(AW'(ent), av, zp, ent[0], res, lat, brdy);
      chk($sformatf("b2b_lat_%0d", ent), 128'(lat), 128'(4));
      chk($sformatf("b2b_ofm_%0d", ent), res, exp);
      if (ent[0]) begin
        seen = 0;
        repeat (6) begin
          @(negedge clk);
          if (done) seen++;
        end
        chk($sformatf("busy_start_ignored_%0d", ent), 128'(seen), 128'(0));
      end
    end

    @(negedge clk);
    addr = 0; acc_vec = rep32(32'd100); out_zp = 8'd37; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_ready", 128'(ready), 128'(1));
    chk("abort_done", 128'(done), 128'(0));
    chk("abort_ofm", ofm_vec, 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("abort_no_done", 128'(seen), 128'(0));
    run_req(1, rep32(-32'sd1000), 8'd37, 1'b0, res, lat, brdy);
    chk("after_abort_lat", 128'(lat), 128'(4));
    chk("after_abort_ofm", res, rep8(8'hE6));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
